mem_port_arb: RTL and testbench
===============================

// Module: mem_port_arb
// PURPOSE
//  Arbiter/sequencer for the single shared memory port of the rv32 pipeline.
//  Serialises instruction fetch (if_*) and load/store (ls_*) requests onto one
//  memory port. Issues one transaction at a time and returns the response to
//  the owner. Sits between fetch_ctl/LSU and the unified memory.
// PARAMETERS
//  MEM_LAT     2  cycles from mem_en high to mem_rdata valid; legal range 1..15
//  STARVE_MAX  4  consecutive contested ls grants before fetch is forced (guard only)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   synchronous reset, active-low (rst==0 resets)
//  if_req     in   1   fetch request; held with if_addr until if_gnt
//  if_addr    in   32  fetch address (word aligned)
//  if_gnt     out  1   fetch accepted this cycle
//  if_rvalid  out  1   fetch data valid (1-cycle pulse)
//  if_rdata   out  32  fetch data; meaningful only when if_rvalid
//  ls_req     in   1   load/store request; held with ls_* until ls_gnt
//  ls_we      in   1   1=store, 0=load
//  ls_be      in   4   byte enables
//  ls_addr    in   32  load/store address
//  ls_wdata   in   32  store data
//  ls_gnt     out  1   load/store accepted this cycle
//  ls_rvalid  out  1   load data valid / store complete (1-cycle pulse)
//  ls_rdata   out  32  load data; meaningful only when ls_rvalid && !we
//  mem_en     out  1   memory access strobe, exactly 1 cycle per transaction
//  mem_we     out  1   memory write enable (qualified by mem_en)
//  mem_be     out  4   memory byte enables (fetch issues 4'hF)
//  mem_addr   out  32  memory address
//  mem_wdata  out  32  memory write data
//  mem_rdata  in   32  memory read data, valid MEM_LAT cycles after mem_en
//  busy       out  1   transaction in flight (state != IDLE)
// BEHAVIOUR
//  - States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  - IDLE: gnt is combinational from req. Only one gnt is ever high at a time.
//    With no req: stay in IDLE. Grant cycle T: the owner and request fields are
//    latched at the T edge, and the FSM goes to ISSUE.
//  - ISSUE (cycle T+1): mem_en=1, mem_* driven from the latched fields.
//    Fetch drives mem_we=0 and mem_be=4'hF.
//    Next state is WAIT. If MEM_LAT==1, next state is RESP directly.
//  - WAIT: a 4-bit down-counter is loaded with MEM_LAT-1 on entry.
//    Go to RESP when the counter reaches 1.
//  - RESP (cycle T+1+MEM_LAT): the owner's rvalid=1.
//    The owner's rdata is mem_rdata (combinational pass-through).
//    Stores also pulse ls_rvalid. Next state is IDLE.
//  - Back-to-back throughput: next gnt at cycle T+2+MEM_LAT earliest;
//    one transaction per MEM_LAT+2 cycles.
//  - Simultaneous if_req and ls_req in IDLE: ls wins (fixed priority),
//    unless the guard below fires.
//  - gnt is never asserted outside IDLE. A req raised while busy waits and is
//    granted in the first IDLE cycle.
//  - mem_en=0, mem_we=0 in every state except ISSUE.
//    mem_addr, mem_be and mem_wdata hold their last values.
//  - Reset (rst==0, any state incl. mid-transaction): next state is IDLE.
//    The pending response is dropped and no rvalid is issued.
//    All outputs are 0: gnts, rvalids, mem_en, mem_we, mem_be, mem_addr,
//    mem_wdata, busy, and the starve counter.
//    Gnts are forced to 0 during reset cycles.
// CONFIGURATION
//  STARVE_GUARD_EN defined:
//  - A 4-bit starve counter increments on each ls grant made while if_req=1.
//  - It clears on any if grant.
//  - When counter==STARVE_MAX and both requests are high in IDLE, if wins.
//  STARVE_GUARD_EN undefined: no counter; strict ls priority; fetch may starve.
// TESTING (MEM_LAT=2, STARVE_MAX=4)
//  1. rst low 3 cycles, then high -> all outputs 0, busy=0; no gnt while rst=0 even with if_req=1.
//  2. if_req, if_addr=0x100 at cycle 0 -> if_gnt@0, mem_en/addr=0x100/be=F@1, mem_rdata=0xDEADBEEF@3 -> if_rvalid, if_rdata=0xDEADBEEF@3, busy@1..3.
//  3. if_req and ls_req (store, addr 0x200, wdata 0x55, be=4'b0011) both at cycle 0 -> ls_gnt@0, mem_we=1@1, ls_rvalid@3, if_gnt@4, if_rvalid@7.
//  4. ls_req held 6 transactions with if_req high -> guard build: if_gnt after 4th ls grant (cycle 16); non-guard build: if_gnt never.
//  5. rst=0 at cycle 2 of a fetch (WAIT) -> no if_rvalid ever; IDLE@3; fresh ls_req at cycle 4 granted at 4.
//  6. MEM_LAT=1 build, load at cycle 0 -> mem_en@1, ls_rvalid@2, next gnt@3.

Source files
------------

// File: rtl/mem_port_arb_if.sv
// mem_port_arb_if: fetch, load/store and memory-port signals of the shared memory arbiter
interface mem_port_arb_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [3:0]  ls_be;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;
  modport master (
    input  if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );
  modport slave (
    output if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arb.sv
// mem_port_arb: serialises fetch and load/store requests onto one memory port.
// Define STARVE_GUARD_EN to force a fetch grant after STARVE_MAX contested ls grants.
module mem_port_arb #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input logic            clk,
  input logic            rst,
  mem_port_arb_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t     state, next_state;
  logic [3:0] cnt;
  logic       own_ls, we_q, idle, force_if;
`ifdef STARVE_GUARD_EN
  logic [3:0] starve;
  always_ff @(posedge clk)
    if (!rst) starve <= '0;
    else if (bus.if_gnt) starve <= '0;
    else if (bus.ls_gnt && bus.if_req) starve <= starve + 4'd1;
  assign force_if = starve == 4'(STARVE_MAX);
`else
  // strict ls priority; STARVE_MAX only matters when the guard is built in
  assign force_if = 1'b0 && STARVE_MAX != 0;
`endif
  always_ff @(posedge clk) state <= !rst ? IDLE : next_state;
  always_comb
    next_state = state == IDLE  ? ((bus.if_gnt || bus.ls_gnt) ? ISSUE : IDLE) :
                 state == ISSUE ? (MEM_LAT == 1 ? RESP : WAIT) :
                 state == WAIT  ? (cnt == 4'd1 ? RESP : WAIT) : IDLE;
  always_comb begin
    idle          = rst && state == IDLE;
    bus.if_gnt    = idle && bus.if_req && (!bus.ls_req || force_if);
    bus.ls_gnt    = idle && bus.ls_req && !bus.if_gnt;
    bus.mem_en    = rst && state == ISSUE;
    bus.mem_we    = bus.mem_en && we_q;
    bus.if_rvalid = rst && state == RESP && !own_ls;
    bus.ls_rvalid = rst && state == RESP && own_ls;
    bus.if_rdata  = bus.mem_rdata;
    bus.ls_rdata  = bus.mem_rdata;
    bus.busy      = rst && state != IDLE;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      own_ls        <= 1'b0;
      we_q          <= 1'b0;
      cnt           <= '0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
    end else begin
      if (bus.if_gnt || bus.ls_gnt) begin
        own_ls       <= bus.ls_gnt;
        we_q         <= bus.ls_gnt && bus.ls_we;
        bus.mem_addr <= bus.ls_gnt ? bus.ls_addr : bus.if_addr;
        bus.mem_be   <= bus.ls_gnt ? bus.ls_be : 4'hF;
        if (bus.ls_gnt) bus.mem_wdata <= bus.ls_wdata;
      end
      // loaded on the ISSUE->WAIT edge so WAIT lasts MEM_LAT-1 cycles
      cnt <= state == ISSUE ? 4'(MEM_LAT - 1) : state == WAIT ? cnt - 4'd1 : cnt;
    end
endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: random and directed stimulus against a transaction-timing reference model
module tb_mem_port_arb;
  localparam int LAT  = 2;
  localparam int SMAX = 4;
`ifdef STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  mem_port_arb_if u ();
  mem_port_arb_if u1 ();
  mem_port_arb #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut  (.clk(clk), .rst(rst), .bus(u));
  mem_port_arb #(.MEM_LAT(1),   .STARVE_MAX(SMAX)) dut1 (.clk(clk), .rst(rst), .bus(u1));
  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
  endtask
  function automatic logic [31:0] rnd_addr();
    return {22'd0, 8'($urandom), 2'b00};
  endfunction
  logic [31:0] dmem    [256];
  logic [31:0] ref_mem [256];
  logic [31:0] pipe    [LAT];
  always @(posedge clk) begin
    if (u.mem_en) begin
      pipe[0] <= dmem[u.mem_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (u.mem_we && u.mem_be[b]) dmem[u.mem_addr[9:2]][8*b +: 8] <= u.mem_wdata[8*b +: 8];
    end else pipe[0] <= 32'h0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign u.mem_rdata = pipe[LAT-1];
  always @(posedge clk) u1.mem_rdata <= u1.mem_en ? {16'hA5A5, u1.mem_addr[15:0]} : 32'h0;
  // Reference: each grant at cycle t0 owns the port until t0+LAT+2
  bit          has_txn = 1'b0, o_ls, o_we, eif, els, frc;
  int          t0 = 0, free_at = 0, starve = 0, dt;
  logic [31:0] e_addr = 32'h0, e_wdata = 32'h0, e_data = 32'h0;
  logic [3:0]  e_be = 4'h0;
  logic [7:0]  idx;
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_if_gnt", u.if_gnt, 0);
      chk("rst_ls_gnt", u.ls_gnt, 0);
      chk("rst_mem_en", u.mem_en, 0);
      chk("rst_mem_we", u.mem_we, 0);
      chk("rst_if_rvalid", u.if_rvalid, 0);
      chk("rst_ls_rvalid", u.ls_rvalid, 0);
      chk("rst_busy", u.busy, 0);
      has_txn = 1'b0;
      free_at = cyc + 1;
      starve  = 0;
      e_addr  = 32'h0;
      e_be    = 4'h0;
      e_wdata = 32'h0;
    end else begin
      dt  = cyc - t0;
      frc = GUARD && starve == SMAX;
      eif = cyc >= free_at && u.if_req && (!u.ls_req || frc);
      els = cyc >= free_at && u.ls_req && !eif;
      chk("if_gnt", u.if_gnt, eif);
      chk("ls_gnt", u.ls_gnt, els);
      chk("mem_en", u.mem_en, has_txn && dt == 1);
      chk("mem_we", u.mem_we, has_txn && dt == 1 && o_we);
      chk("if_rvalid", u.if_rvalid, has_txn && dt == LAT + 1 && !o_ls);
      chk("ls_rvalid", u.ls_rvalid, has_txn && dt == LAT + 1 && o_ls);
      chk("busy", u.busy, has_txn && dt >= 1 && dt <= LAT + 1);
      if (has_txn && dt == LAT + 1 && !o_ls) chk("if_rdata", u.if_rdata, e_data);
      if (has_txn && dt == LAT + 1 && o_ls && !o_we) chk("ls_rdata", u.ls_rdata, e_data);
      chk("mem_addr", u.mem_addr, e_addr);
      chk("mem_be", u.mem_be, e_be);
      chk("mem_wdata", u.mem_wdata, e_wdata);
      if (eif || els) begin
        has_txn = 1'b1;
        t0      = cyc;
        free_at = cyc + LAT + 2;
        o_ls    = els;
        o_we    = els && u.ls_we;
        e_addr  = els ? u.ls_addr : u.if_addr;
        e_be    = els ? u.ls_be : 4'hF;
        if (els) e_wdata = u.ls_wdata;
        idx     = e_addr[9:2];
        e_data  = ref_mem[idx];
        if (o_we)
          for (int b = 0; b < 4; b++)
            if (u.ls_be[b]) ref_mem[idx][8*b +: 8] = u.ls_wdata[8*b +: 8];
        if (eif) starve = 0;
        else if (u.if_req) starve++;
      end
    end
  end
  bit if_took, ls_took;
  int last_if = -1, last_ls = -1, s;
  task automatic run(int n, int p_if, int p_ls, bit p_rst);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if_took = u.if_gnt;
      ls_took = u.ls_gnt;
      if (if_took) last_if = cyc;
      if (ls_took) last_ls = cyc;
      @(posedge clk);
      #1;
      if (p_rst) rst = $urandom_range(99) != 0;
      if (if_took) u.if_req = 1'b0;
      if (!u.if_req && $urandom_range(99) < p_if) begin
        u.if_req  = 1'b1;
        u.if_addr = rnd_addr();
      end
      if (ls_took) u.ls_req = 1'b0;
      if (!u.ls_req && $urandom_range(99) < p_ls) begin
        u.ls_req   = 1'b1;
        u.ls_we    = 1'($urandom);
        u.ls_be    = 4'($urandom);
        u.ls_addr  = rnd_addr();
        u.ls_wdata = $urandom;
      end
    end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) begin
      dmem[i]    = (i * 32'h01010101) ^ 32'h13572468;
      ref_mem[i] = dmem[i];
    end
    dmem[64] = 32'hDEADBEEF;
    ref_mem[64] = 32'hDEADBEEF;
    for (int i = 0; i < LAT; i++) pipe[i] = 32'h0;
    {u.if_req, u.if_addr, u.ls_req, u.ls_we, u.ls_be, u.ls_addr, u.ls_wdata} = '0;
    {u1.if_req, u1.if_addr, u1.ls_req, u1.ls_we, u1.ls_be, u1.ls_addr, u1.ls_wdata} = '0;
    u.if_req  = 1'b1;
    u.if_addr = 32'h100;
    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b1;
    u.if_req = 1'b0;
    run(3, 0, 0, 0);
    chk("t1_mem_addr", u.mem_addr, 32'h0);
    chk("t1_mem_be", u.mem_be, 4'h0);
    u.if_req  = 1'b1;
    u.if_addr = 32'h100;
    run(8, 0, 0, 0);
    {u.ls_req, u.ls_we, u.ls_be, u.ls_addr, u.ls_wdata} = {1'b1, 1'b1, 4'b0011, 32'h200, 32'h55};
    u.if_req  = 1'b1;
    u.if_addr = 32'h104;
    s = cyc;
    run(12, 0, 0, 0);
    chk("t3_ls_gnt_at", last_ls - s, 0);
    chk("t3_if_gnt_at", last_if - s, 4);
    u.if_req  = 1'b1;
    u.if_addr = 32'h108;
    {u.ls_req, u.ls_we, u.ls_be, u.ls_addr, u.ls_wdata} = {1'b1, 1'b0, 4'hF, 32'h10, 32'h0};
    s = cyc;
    run(24, 0, 100, 0);
    chk("t4_if_gnt_at", last_if >= s ? last_if - s : -1, GUARD ? 16 : -1);
    run(20, 0, 0, 0);
    u.if_req  = 1'b1;
    u.if_addr = 32'h10C;
    run(2, 0, 0, 0);
    rst = 1'b0;
    run(1, 0, 0, 0);
    rst = 1'b1;
    run(1, 0, 0, 0);
    {u.ls_req, u.ls_we, u.ls_be, u.ls_addr, u.ls_wdata} = {1'b1, 1'b0, 4'hF, 32'h100, 32'h0};
    s = cyc;
    run(8, 0, 0, 0);
    chk("t5_ls_gnt_at", last_ls - s, 0);
    {u1.ls_req, u1.ls_we, u1.ls_be, u1.ls_addr} = {1'b1, 1'b0, 4'hF, 32'h40};
    @(negedge clk);
    chk("t6_gnt0", u1.ls_gnt, 1);
    @(posedge clk);
    #1;
    u1.ls_addr = 32'h44;
    @(negedge clk);
    chk("t6_mem_en1", u1.mem_en, 1);
    chk("t6_addr1", u1.mem_addr, 32'h40);
    @(negedge clk);
    chk("t6_rvalid2", u1.ls_rvalid, 1);
    chk("t6_rdata2", u1.ls_rdata, 32'hA5A50040);
    chk("t6_gnt2", u1.ls_gnt, 0);
    chk("t6_mem_en2", u1.mem_en, 0);
    @(negedge clk);
    chk("t6_gnt3", u1.ls_gnt, 1);
    @(posedge clk);
    #1;
    u1.ls_req = 1'b0;
    run(3000, 35, 35, 1);
    rst = 1'b1;
    run(20, 0, 0, 0);
    chk("drain_if_req", u.if_req, 0);
    chk("drain_ls_req", u.ls_req, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
